// File: rtl/control_sequencer.sv
// Multi-cycle MIPS control unit: Moore-decoded datapath strobes from a 7-bit state
// register, encoder-driven dispatch in DECODE, and MOC-handshaked memory waits with timeout.
module control_sequencer #(
  parameter int unsigned MOC_TIMEOUT = 16
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [6:0] State_Sel,
  input  logic       Zero,
  input  logic       MOC,
  output logic [6:0] State,
  output logic       MAR_Ld,
  output logic       MDR_Ld,
  output logic       IR_Ld,
  output logic       PC_Ld,
  output logic       RF_Ld,
  output logic       PC_Sel,
  output logic       MDR_Src,
  output logic       B_Sel,
  output logic [2:0] ALU_Op,
  output logic       RF_Dst,
  output logic       RF_Src,
  output logic       MemEnable,
  output logic       MemRW,
  output logic       Illegal,
  output logic       Bus_Error
);

  typedef enum logic [6:0] {
    S_RESET    = 7'd0,
    S_FETCH_A  = 7'd1,
    S_FETCH_W  = 7'd2,
    S_FETCH_D  = 7'd3,
    S_DECODE   = 7'd4,
    S_ADDU     = 7'd6,
    S_ST_ADDR  = 7'd7,
    S_ST_DATA  = 7'd8,
    S_ST_W     = 7'd9,
    S_BEQ_CMP  = 7'd11,
    S_BEQ_TAKE = 7'd12,
    S_LD_ADDR  = 7'd13,
    S_LD_W     = 7'd14,
    S_LD_WB    = 7'd15,
    S_SUBU     = 7'd17,
    S_ADDIU    = 7'd18,
    S_SLTU     = 7'd19,
    S_FAULT    = 7'd127
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLTU = 3'b010;

  // Last counter value at which a missing MOC still leaves the block waiting.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MOC_TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;
  logic       in_wait;
  logic       timed_out;
  state_t     wait_exit;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_RESET;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    in_wait   = 1'b0;
    wait_exit = S_FETCH_A;
    case (state)
      S_FETCH_W: begin in_wait = 1'b1; wait_exit = S_FETCH_D; end
      S_ST_W:    begin in_wait = 1'b1; wait_exit = S_FETCH_A; end
      S_LD_W:    begin in_wait = 1'b1; wait_exit = S_LD_WB;   end
      default:   begin in_wait = 1'b0; wait_exit = S_FETCH_A; end
    endcase
  end

  assign timed_out = (wait_cnt == TIMEOUT_LAST);

  // Next state; MOC takes priority over the timeout when both occur on the same edge.
  always_comb begin
    state_nxt = S_RESET;
    Illegal   = 1'b0;
    case (state)
      S_RESET:    state_nxt = S_FETCH_A;
      S_FETCH_A:  state_nxt = S_FETCH_W;
      S_FETCH_D:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (State_Sel)
          7'd6, 7'd7, 7'd11, 7'd13, 7'd17, 7'd18, 7'd19:
            state_nxt = state_t'(State_Sel);
          default: begin
            Illegal   = 1'b1;
            state_nxt = S_FETCH_A;
          end
        endcase
      end
      S_ADDU, S_SUBU, S_SLTU, S_ADDIU, S_BEQ_TAKE, S_LD_WB:
                  state_nxt = S_FETCH_A;
      S_ST_ADDR:  state_nxt = S_ST_DATA;
      S_ST_DATA:  state_nxt = S_ST_W;
      S_LD_ADDR:  state_nxt = S_LD_W;
      S_BEQ_CMP:  state_nxt = Zero ? S_BEQ_TAKE : S_FETCH_A;
      S_FETCH_W, S_ST_W, S_LD_W: begin
        if (MOC)
          state_nxt = wait_exit;
        else if (timed_out)
          state_nxt = S_FAULT;
        else
          state_nxt = state;
      end
      S_FAULT:    state_nxt = S_FAULT;
      default:    state_nxt = S_RESET;
    endcase
  end

  // Counter restarts on every wait-state entry, so consecutive waits each get a full budget.
  always_comb begin
    wait_cnt_nxt = 8'd0;
    if (in_wait && (state_nxt == state))
      wait_cnt_nxt = wait_cnt + 8'd1;
  end

  // Moore output decode: every strobe is a pure function of the state register.
  always_comb begin
    MAR_Ld    = 1'b0;
    MDR_Ld    = 1'b0;
    IR_Ld     = 1'b0;
    PC_Ld     = 1'b0;
    RF_Ld     = 1'b0;
    PC_Sel    = 1'b0;
    MDR_Src   = 1'b0;
    B_Sel     = 1'b0;
    ALU_Op    = ALU_ADD;
    RF_Dst    = 1'b0;
    RF_Src    = 1'b0;
    MemEnable = 1'b0;
    MemRW     = 1'b0;
    Bus_Error = 1'b0;
    case (state)
      S_FETCH_A: MAR_Ld = 1'b1;
      S_FETCH_W: begin
        MemEnable = 1'b1;
        MemRW     = 1'b1;
        MDR_Ld    = 1'b1;
      end
      S_FETCH_D: begin
        IR_Ld = 1'b1;
        PC_Ld = 1'b1;
      end
      S_ADDU: begin
        ALU_Op = ALU_ADD;
        RF_Ld  = 1'b1;
      end
      S_SUBU: begin
        ALU_Op = ALU_SUB;
        RF_Ld  = 1'b1;
      end
      S_SLTU: begin
        ALU_Op = ALU_SLTU;
        RF_Ld  = 1'b1;
      end
      S_ADDIU: begin
        ALU_Op = ALU_ADD;
        B_Sel  = 1'b1;
        RF_Dst = 1'b1;
        RF_Ld  = 1'b1;
      end
      S_ST_ADDR, S_LD_ADDR: begin
        B_Sel  = 1'b1;
        MAR_Ld = 1'b1;
      end
      S_ST_DATA: begin
        MDR_Src = 1'b1;
        MDR_Ld  = 1'b1;
      end
      S_ST_W: MemEnable = 1'b1;
      S_BEQ_CMP: ALU_Op = ALU_SUB;
      S_BEQ_TAKE: begin
        PC_Ld  = 1'b1;
        PC_Sel = 1'b1;
      end
      S_LD_W: begin
        MemEnable = 1'b1;
        MemRW     = 1'b1;
        MDR_Ld    = 1'b1;
      end
      S_LD_WB: begin
        RF_Ld  = 1'b1;
        RF_Dst = 1'b1;
        RF_Src = 1'b1;
      end
      S_FAULT: Bus_Error = 1'b1;
      default: ;
    endcase
  end

  assign State = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: instruction flows, MOC waits, timeout fault and reset.
module tb_control_sequencer;

  logic       Clk;
  logic       Reset_n;
  logic [6:0] State_Sel;
  logic       Zero;
  logic       MOC;
  logic [6:0] State;
  logic       MAR_Ld, MDR_Ld, IR_Ld, PC_Ld, RF_Ld, PC_Sel, MDR_Src, B_Sel;
  logic [2:0] ALU_Op;
  logic       RF_Dst, RF_Src, MemEnable, MemRW, Illegal, Bus_Error;
  logic [16:0] ctl;

  int n_pass = 0;
  int n_chk  = 0;

  control_sequencer #(.MOC_TIMEOUT(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .State_Sel(State_Sel), .Zero(Zero), .MOC(MOC),
    .State(State), .MAR_Ld(MAR_Ld), .MDR_Ld(MDR_Ld), .IR_Ld(IR_Ld), .PC_Ld(PC_Ld),
    .RF_Ld(RF_Ld), .PC_Sel(PC_Sel), .MDR_Src(MDR_Src), .B_Sel(B_Sel), .ALU_Op(ALU_Op),
    .RF_Dst(RF_Dst), .RF_Src(RF_Src), .MemEnable(MemEnable), .MemRW(MemRW),
    .Illegal(Illegal), .Bus_Error(Bus_Error)
  );

  assign ctl = {MAR_Ld, MDR_Ld, IR_Ld, PC_Ld, RF_Ld, PC_Sel, MDR_Src, B_Sel, ALU_Op,
                RF_Dst, RF_Src, MemEnable, MemRW, Illegal, Bus_Error};

  localparam logic [16:0] B_MAR  = 17'd1 << 16;
  localparam logic [16:0] B_MDR  = 17'd1 << 15;
  localparam logic [16:0] B_IR   = 17'd1 << 14;
  localparam logic [16:0] B_PC   = 17'd1 << 13;
  localparam logic [16:0] B_RF   = 17'd1 << 12;
  localparam logic [16:0] B_PCS  = 17'd1 << 11;
  localparam logic [16:0] B_MSRC = 17'd1 << 10;
  localparam logic [16:0] B_BSEL = 17'd1 << 9;
  localparam logic [16:0] A_SUB  = 17'd1 << 6;
  localparam logic [16:0] A_SLTU = 17'd2 << 6;
  localparam logic [16:0] B_DST  = 17'd1 << 5;
  localparam logic [16:0] B_SRC  = 17'd1 << 4;
  localparam logic [16:0] B_MEN  = 17'd1 << 3;
  localparam logic [16:0] B_MRW  = 17'd1 << 2;
  localparam logic [16:0] B_ILL  = 17'd1 << 1;
  localparam logic [16:0] B_BERR = 17'd1;

  localparam logic [16:0] C_FETCH_W = B_MEN | B_MRW | B_MDR;
  localparam logic [16:0] C_FETCH_D = B_IR | B_PC;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock and check state and the whole output bundle just after the edge.
  task automatic cyc(input string tag, input logic [6:0] es, input logic [16:0] ec);
    @(posedge Clk);
    #1;
    chk({tag, ".state"}, 32'(State), 32'(es));
    chk({tag, ".ctl"}, 32'(ctl), 32'(ec));
  endtask

  initial begin
    Reset_n   = 1'b0;
    State_Sel = 7'd6;
    Zero      = 1'b0;
    MOC       = 1'b1;
    #3;
    chk("rst.state", 32'(State), 32'd0);
    chk("rst.ctl", 32'(ctl), 32'd0);
    @(posedge Clk);
    #1;
    chk("rst_hold.state", 32'(State), 32'd0);
    Reset_n = 1'b1;

    // ADDU, zero-wait memory
    cyc("addu.fa", 7'd1, B_MAR);
    cyc("addu.fw", 7'd2, C_FETCH_W);
    cyc("addu.fd", 7'd3, C_FETCH_D);
    cyc("addu.dec", 7'd4, 17'd0);
    cyc("addu.ex", 7'd6, B_RF);
    cyc("addu.next", 7'd1, B_MAR);

    // Load with MOC arriving on the 4th wait cycle (coincides with timeout count)
    State_Sel = 7'd13;
    cyc("ld.fw", 7'd2, C_FETCH_W);
    cyc("ld.fd", 7'd3, C_FETCH_D);
    cyc("ld.dec", 7'd4, 17'd0);
    cyc("ld.addr", 7'd13, B_BSEL | B_MAR);
    MOC = 1'b0;
    cyc("ld.w1", 7'd14, C_FETCH_W);
    cyc("ld.w2", 7'd14, C_FETCH_W);
    cyc("ld.w3", 7'd14, C_FETCH_W);
    cyc("ld.w4", 7'd14, C_FETCH_W);
    MOC = 1'b1;
    cyc("ld.wb", 7'd15, B_RF | B_SRC | B_DST);
    cyc("ld.next", 7'd1, B_MAR);

    // BEQ taken
    State_Sel = 7'd11;
    Zero      = 1'b1;
    cyc("beqt.fw", 7'd2, C_FETCH_W);
    cyc("beqt.fd", 7'd3, C_FETCH_D);
    cyc("beqt.dec", 7'd4, 17'd0);
    cyc("beqt.cmp", 7'd11, A_SUB);
    cyc("beqt.take", 7'd12, B_PC | B_PCS);
    cyc("beqt.next", 7'd1, B_MAR);

    // BEQ not taken
    Zero = 1'b0;
    cyc("beqn.fw", 7'd2, C_FETCH_W);
    cyc("beqn.fd", 7'd3, C_FETCH_D);
    cyc("beqn.dec", 7'd4, 17'd0);
    cyc("beqn.cmp", 7'd11, A_SUB);
    cyc("beqn.next", 7'd1, B_MAR);

    // Illegal selectors 0 and 20
    State_Sel = 7'd0;
    cyc("ill0.fw", 7'd2, C_FETCH_W);
    cyc("ill0.fd", 7'd3, C_FETCH_D);
    cyc("ill0.dec", 7'd4, B_ILL);
    cyc("ill0.next", 7'd1, B_MAR);
    State_Sel = 7'd20;
    cyc("ill20.fw", 7'd2, C_FETCH_W);
    cyc("ill20.fd", 7'd3, C_FETCH_D);
    cyc("ill20.dec", 7'd4, B_ILL);
    cyc("ill20.next", 7'd1, B_MAR);

    // SUBU, SLTU, ADDIU decode
    State_Sel = 7'd17;
    cyc("subu.fw", 7'd2, C_FETCH_W);
    cyc("subu.fd", 7'd3, C_FETCH_D);
    cyc("subu.dec", 7'd4, 17'd0);
    cyc("subu.ex", 7'd17, B_RF | A_SUB);
    State_Sel = 7'd19;
    cyc("sltu.fa", 7'd1, B_MAR);
    cyc("sltu.fw", 7'd2, C_FETCH_W);
    cyc("sltu.fd", 7'd3, C_FETCH_D);
    cyc("sltu.dec", 7'd4, 17'd0);
    cyc("sltu.ex", 7'd19, B_RF | A_SLTU);
    State_Sel = 7'd18;
    cyc("addiu.fa", 7'd1, B_MAR);
    cyc("addiu.fw", 7'd2, C_FETCH_W);
    cyc("addiu.fd", 7'd3, C_FETCH_D);
    cyc("addiu.dec", 7'd4, 17'd0);
    cyc("addiu.ex", 7'd18, B_RF | B_BSEL | B_DST);

    // Fetch wait where MOC and timeout coincide: MOC wins
    cyc("coin.fa", 7'd1, B_MAR);
    MOC = 1'b0;
    cyc("coin.w1", 7'd2, C_FETCH_W);
    cyc("coin.w2", 7'd2, C_FETCH_W);
    cyc("coin.w3", 7'd2, C_FETCH_W);
    cyc("coin.w4", 7'd2, C_FETCH_W);
    MOC = 1'b1;
    cyc("coin.fd", 7'd3, C_FETCH_D);

    // Store whose write never completes: timeout into FAULT
    State_Sel = 7'd7;
    cyc("st.dec", 7'd4, 17'd0);
    cyc("st.addr", 7'd7, B_BSEL | B_MAR);
    cyc("st.data", 7'd8, B_MSRC | B_MDR);
    MOC = 1'b0;
    cyc("st.w1", 7'd9, B_MEN);
    cyc("st.w2", 7'd9, B_MEN);
    cyc("st.w3", 7'd9, B_MEN);
    cyc("st.w4", 7'd9, B_MEN);
    cyc("flt.1", 7'd127, B_BERR);
    MOC = 1'b1;
    cyc("flt.2", 7'd127, B_BERR);
    cyc("flt.3", 7'd127, B_BERR);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("flt_rst.state", 32'(State), 32'd0);
    chk("flt_rst.berr", 32'(Bus_Error), 32'd0);

    // Reset asserted mid fetch-wait drops MemEnable at once
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    cyc("mw.fa", 7'd1, B_MAR);
    MOC = 1'b0;
    cyc("mw.fw", 7'd2, C_FETCH_W);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("mw_rst.state", 32'(State), 32'd0);
    chk("mw_rst.men", 32'(MemEnable), 32'd0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    cyc("mw.restart", 7'd1, B_MAR);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control unit for the MIPS datapath. It owns the 7-bit control-state register and drives every datapath load strobe, mux select and memory request as a Moore function of the current state. It sequences fetch, decode and the execute/memory states. The dispatch target is taken from the 7-bit state selector produced by the instruction encoder, which sits combinationally between the IR and this block. Memory accesses use a MOC (memory-operation-complete) handshake with a bounded wait.

## Interface
- MOC_TIMEOUT, 16: maximum cycles spent in a memory-wait state without MOC before faulting; legal range 2..255.
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- State_Sel  input  7  dispatch target from the encoder; sampled only in DECODE.
- Zero  input  1  ALU zero flag; sampled only in BEQ_CMP.
- MOC  input  1  memory operation complete; sampled only in wait states.
- State  output  7  current state register.
- MAR_Ld, MDR_Ld, IR_Ld, PC_Ld, RF_Ld  output  1 each  register load strobes.
- PC_Sel  output  1  PC source: 0 = PC+4, 1 = branch target.
- MDR_Src  output  1  MDR source: 0 = memory, 1 = rt.
- B_Sel  output  1  ALU B operand: 0 = rt, 1 = sign-extended immediate.
- ALU_Op  output  3  operation: 000 add, 001 sub, 010 set-less-than-unsigned.
- RF_Dst  output  1  register-file destination: 0 = rd, 1 = rt.
- RF_Src  output  1  register-file source: 0 = ALU, 1 = MDR.
- MemEnable  output  1  memory request.
- MemRW  output  1  memory direction: 1 = read, 0 = write.
- Illegal  output  1  one-cycle pulse when DECODE sees an unsupported selector.
- Bus_Error  output  1  sticky; high while in FAULT.

## Operation
- State encodings (decimal), their outputs (all unlisted outputs are 0), and next state:
  - 0 RESET: no outputs. Next: 1.
  - 1 FETCH_A: MAR_Ld. Next: 2.
  - 2 FETCH_W: MemEnable, MemRW, MDR_Ld. Waits on MOC, then 3.
  - 3 FETCH_D: IR_Ld, PC_Ld (PC_Sel=0). Next: 4.
  - 4 DECODE: no outputs. Next: State_Sel if it is one of {6,7,11,13,17,18,19}; otherwise Illegal=1 and next is 1.
  - 6 ADDU: ALU_Op=000, RF_Ld. Next: 1.
  - 17 SUBU: ALU_Op=001, RF_Ld. Next: 1.
  - 19 SLTU: ALU_Op=010, RF_Ld. Next: 1.
  - 18 ADDIU: ALU_Op=000, B_Sel, RF_Dst, RF_Ld. Next: 1.
  - 7 ST_ADDR: B_Sel, MAR_Ld. Next: 8.
  - 8 ST_DATA: MDR_Src, MDR_Ld. Next: 9.
  - 9 ST_W: MemEnable (MemRW=0). Waits on MOC, then 1.
  - 11 BEQ_CMP: ALU_Op=001. Next: 12 if Zero, else 1.
  - 12 BEQ_TAKE: PC_Ld, PC_Sel. Next: 1.
  - 13 LD_ADDR: B_Sel, MAR_Ld. Next: 14.
  - 14 LD_W: MemEnable, MemRW, MDR_Ld. Waits on MOC, then 15.
  - 15 LD_WB: RF_Ld, RF_Dst, RF_Src. Next: 1.
  - 127 FAULT: Bus_Error. Stays in FAULT until reset.
  - Any other value: next is 0.
- Wait states are 2, 9 and 14.
  - An 8-bit wait counter clears on entry to a wait state and increments each cycle spent in it.
  - If MOC=1 at the edge, the block advances.
  - If MOC=0 and the counter equals MOC_TIMEOUT-1, the next state is 127.
  - If MOC and timeout coincide, MOC wins.
- MemEnable is held continuously through a wait; it drops in the cycle after MOC is accepted.

## Timing
- Reset asserted: asynchronously, State=0, the wait counter is 0, and all outputs are 0 (Bus_Error included).
- Reset mid-wait: MemEnable drops immediately.
- After Reset_n deasserts: the first edge goes to 1.
- All outputs are decoded from the State register; there are no combinational paths from inputs to outputs.
  - Exception: Illegal is high in DECODE whenever State_Sel is unsupported.
- Cycle counts with zero-wait memory (MOC high on the first wait cycle):
  - R-type/ADDIU: 5 cycles (FETCH_A to execute).
  - BEQ not taken: 5 cycles; taken: 6 cycles.
  - Load: 7 cycles. Store: 7 cycles.
  - Each extra MOC wait cycle adds 1.
- Back-to-back instructions: the cycle after the last state of an instruction is FETCH_A.

## Test plan
- Reset then run with MOC tied high and State_Sel=6 -> State sequence 0,1,2,3,4,6,1; RF_Ld high only in state 6; ALU_Op=000.
- Load with State_Sel=13 and MOC delayed 3 cycles in state 14 -> MemEnable and MemRW high for 4 cycles; then 15 with RF_Ld=RF_Src=RF_Dst=1; then 1.
- BEQ with State_Sel=11 -> Zero=1 gives 11,12 (PC_Ld=PC_Sel=1),1; Zero=0 gives 11,1 with PC_Ld=0.
- Illegal dispatch with State_Sel=0 and with State_Sel=20 -> Illegal high for exactly one cycle in state 4, next state 1, no strobes asserted.
- Timeout with MOC_TIMEOUT=4 and MOC held low in state 9 -> 4 cycles in state 9, then 127 with Bus_Error=1 held. MOC rising later is ignored. Reset_n low returns State=0 and Bus_Error=0 immediately.
- Coincidence with MOC_TIMEOUT=4 and MOC rising in the 4th wait cycle of state 2 -> next state 3, no fault.
